// File: rtl/axi_dmem.sv
// -----------------------------------------------------------------------------
// axi_dmem -- AXI4-Lite slave data memory for the core's load/store path.
//
// Backs loads and stores with a word-wide block RAM and honours byte strobes.
// The read and write paths are independent FSMs, so one read and one write
// transaction can each be in flight at the same time. Every request gets
// exactly one response.
//
// Parameters
//   BASE_ADDR    byte address of word 0 (aligned to 4*DEPTH_WORDS)
//   DEPTH_WORDS  memory depth in 32-bit words (power of two, >= 4)
//
// Optional feature macro
//   AXI_DMEM_RANGE_CHECK_EN  when defined, accesses outside
//                            [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) answer
//                            SLVERR: reads return 0, writes are suppressed.
//                            When undefined, addresses wrap modulo the depth
//                            and every response is OKAY.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   axi_ar* / axi_r*          read address and read data channels
//   axi_aw* / axi_w* / axi_b* write address, write data, write response
//   axi_arprot, axi_awprot    accepted and ignored
// -----------------------------------------------------------------------------
module axi_dmem #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] axi_araddr,
   input  logic        axi_arvalid,
   output logic        axi_arready,
   input  logic [2:0]  axi_arprot,
   output logic [31:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rvalid,
   input  logic        axi_rready,
   input  logic [31:0] axi_awaddr,
   input  logic        axi_awvalid,
   output logic        axi_awready,
   input  logic [2:0]  axi_awprot,
   input  logic [31:0] axi_wdata,
   input  logic [3:0]  axi_wstrb,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   output logic [1:0]  axi_bresp,
   output logic        axi_bvalid,
   input  logic        axi_bready
);

   localparam int          IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP}   rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wr_state_t;

   rd_state_t        rd_state;
   wr_state_t        wr_state;

   logic [31:0]      mem [DEPTH_WORDS];

   logic [31:0]      rd_addr_p0;
   logic [31:0]      wr_addr_p0;
   logic [31:0]      wr_data_p0;
   logic [3:0]       wr_strb_p0;

   logic             aw_got;
   logic             w_got;
   logic             aw_got_n;
   logic             w_got_n;
   logic             ar_hs;
   logic             aw_hs;
   logic             w_hs;

   logic [31:0]      rd_off;
   logic [31:0]      wr_off;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             rd_ok;
   logic             wr_ok;

   function automatic logic [1:0] resp_code(input logic ok);
      return ok ? OKAY : SLVERR;
   endfunction

   // Handshakes are only possible in IDLE, where the readys are raised.
   assign ar_hs    = (rd_state == R_IDLE) && axi_arvalid && axi_arready;
   assign aw_hs    = (wr_state == W_IDLE) && axi_awvalid && axi_awready;
   assign w_hs     = (wr_state == W_IDLE) && axi_wvalid  && axi_wready;
   assign aw_got_n = aw_got | aw_hs;
   assign w_got_n  = w_got  | w_hs;

   // Word index is the offset from BASE_ADDR with the byte lane bits dropped;
   // the upper bits fall away, which gives the wrap-around when unchecked.
   assign rd_off = rd_addr_p0 - BASE_ADDR;
   assign wr_off = wr_addr_p0 - BASE_ADDR;
   assign rd_idx = rd_off[IDX_W+1:2];
   assign wr_idx = wr_off[IDX_W+1:2];

`ifdef AXI_DMEM_RANGE_CHECK_EN
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

   // An address below BASE_ADDR wraps to a huge offset and fails the compare.
   assign rd_ok = ({1'b0, rd_off} < MEM_BYTES);
   assign wr_ok = ({1'b0, wr_off} < MEM_BYTES);
`else
   assign rd_ok = 1'b1;
   assign wr_ok = 1'b1;
`endif

   logic unused_bits;
   assign unused_bits = &{1'b0, axi_arprot, axi_awprot, rd_off, wr_off};

   // ---- address/data capture stage (p0) ----
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         rd_addr_p0 <= axi_araddr;
      end
      if (aw_hs) begin
         wr_addr_p0 <= axi_awaddr;
      end
      if (w_hs) begin
         wr_data_p0 <= axi_wdata;
         wr_strb_p0 <= axi_wstrb;
      end
   end

   // ---- read FSM: registered RAM read in R_MEM, response held in R_RESP ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state    <= R_IDLE;
         axi_arready <= 1'b0;
         axi_rvalid  <= 1'b0;
         axi_rdata   <= '0;
         axi_rresp   <= OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  axi_arready <= 1'b0;
                  rd_state    <= R_MEM;
               end else begin
                  axi_arready <= 1'b1;
               end
            end
            R_MEM: begin
               // Same-edge write to this word is not visible: read-first.
               axi_rdata  <= rd_ok ? mem[rd_idx] : '0;
               axi_rresp  <= resp_code(rd_ok);
               axi_rvalid <= 1'b1;
               rd_state   <= R_RESP;
            end
            R_RESP: begin
               if (axi_rready) begin
                  axi_rvalid  <= 1'b0;
                  axi_arready <= 1'b1;
                  rd_state    <= R_IDLE;
               end
            end
            default: begin
               rd_state <= R_IDLE;
            end
         endcase
      end
   end

   // ---- write FSM: gather AW and W in any order, commit, then respond ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state    <= W_IDLE;
         axi_awready <= 1'b0;
         axi_wready  <= 1'b0;
         axi_bvalid  <= 1'b0;
         axi_bresp   <= OKAY;
         aw_got      <= 1'b0;
         w_got       <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_got_n && w_got_n) begin
                  axi_awready <= 1'b0;
                  axi_wready  <= 1'b0;
                  aw_got      <= 1'b0;
                  w_got       <= 1'b0;
                  wr_state    <= W_WRITE;
               end else begin
                  // Each ready stays up only until its own channel is captured.
                  axi_awready <= ~aw_got_n;
                  axi_wready  <= ~w_got_n;
                  aw_got      <= aw_got_n;
                  w_got       <= w_got_n;
               end
            end
            W_WRITE: begin
               axi_bresp  <= resp_code(wr_ok);
               axi_bvalid <= 1'b1;
               wr_state   <= W_RESP;
            end
            W_RESP: begin
               if (axi_bready) begin
                  axi_bvalid  <= 1'b0;
                  axi_awready <= 1'b1;
                  axi_wready  <= 1'b1;
                  wr_state    <= W_IDLE;
               end
            end
            default: begin
               wr_state <= W_IDLE;
            end
         endcase
      end
   end

   // ---- memory commit stage: byte-enabled write while in W_WRITE ----
   always_ff @(posedge clk) begin
      if (wr_state == W_WRITE && wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb_p0[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data_p0[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_dmem.sv
// -----------------------------------------------------------------------------
// tb_axi_dmem -- directed self-checking bench for axi_dmem (default params).
// Each scenario task drives its own stimulus and checks results inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_dmem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] axi_araddr = '0;
   logic        axi_arvalid = 1'b0;
   logic        axi_arready;
   logic [2:0]  axi_arprot = '0;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready = 1'b0;
   logic [31:0] axi_awaddr = '0;
   logic        axi_awvalid = 1'b0;
   logic        axi_awready;
   logic [2:0]  axi_awprot = '0;
   logic [31:0] axi_wdata = '0;
   logic [3:0]  axi_wstrb = '0;
   logic        axi_wvalid = 1'b0;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_dmem dut (
      .clk         (clk),
      .rst         (rst),
      .axi_araddr  (axi_araddr),
      .axi_arvalid (axi_arvalid),
      .axi_arready (axi_arready),
      .axi_arprot  (axi_arprot),
      .axi_rdata   (axi_rdata),
      .axi_rresp   (axi_rresp),
      .axi_rvalid  (axi_rvalid),
      .axi_rready  (axi_rready),
      .axi_awaddr  (axi_awaddr),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_awprot  (axi_awprot),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full write transaction; lat counts cycles from the later handshake to bvalid.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output bit to);
      bit aw_done = 0;
      bit w_done  = 0;
      int cyc     = 0;
      to = 0; lat = 0; resp = 2'b11;
      axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
      axi_awvalid = 1; axi_wvalid = 1; axi_bready = 1;
      while (!(aw_done && w_done)) begin
         if (axi_awvalid && axi_awready) aw_done = 1;
         if (axi_wvalid && axi_wready) w_done = 1;
         step();
         if (aw_done) axi_awvalid = 0;
         if (w_done) axi_wvalid = 0;
         cyc++;
         if (cyc > 20) begin
            axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; to = 1;
            return;
         end
      end
      lat = 1;
      while (!axi_bvalid) begin
         step();
         lat++;
         if (lat > 20) begin
            axi_bready = 0; to = 1;
            return;
         end
      end
      resp = axi_bresp;
      step();
      axi_bready = 0;
   endtask

   // Full read transaction; lat counts cycles from the AR handshake to rvalid.
   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output bit to);
      int cyc = 0;
      to = 0; lat = 0; d = '0; resp = 2'b11;
      axi_araddr = a; axi_arvalid = 1; axi_rready = 1;
      while (!axi_arready) begin
         step();
         cyc++;
         if (cyc > 20) begin
            axi_arvalid = 0; axi_rready = 0; to = 1;
            return;
         end
      end
      step();
      axi_arvalid = 0;
      lat = 1;
      while (!axi_rvalid) begin
         step();
         lat++;
         if (lat > 20) begin
            axi_rready = 0; to = 1;
            return;
         end
      end
      d = axi_rdata; resp = axi_rresp;
      step();
      axi_rready = 0;
   endtask

   task automatic test_reset();
      step(); step();
      checks++;
      if ({axi_arready, axi_awready, axi_wready} !== 3'b000) begin
         failures++; $display("FAIL reset_readys got=%b exp=000", {axi_arready, axi_awready, axi_wready});
      end
      checks++;
      if ({axi_rvalid, axi_bvalid} !== 2'b00) begin
         failures++; $display("FAIL reset_valids got=%b exp=00", {axi_rvalid, axi_bvalid});
      end
      checks++;
      if (axi_rdata !== 32'h0 || axi_rresp !== 2'b00 || axi_bresp !== 2'b00) begin
         failures++; $display("FAIL reset_payload rdata=%h rresp=%b bresp=%b exp=0/00/00", axi_rdata, axi_rresp, axi_bresp);
      end
      rst = 0;
      step();
      checks++;
      if ({axi_arready, axi_awready, axi_wready} !== 3'b111) begin
         failures++; $display("FAIL ready_rise got=%b exp=111", {axi_arready, axi_awready, axi_wready});
      end
   endtask

   task automatic test_full_word();
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      bit          to;
      do_write(32'h100, 32'hDEADBEEF, 4'hF, r, lat, to);
      checks++;
      if (to || lat !== 2 || r !== 2'b00) begin
         failures++; $display("FAIL full_write to=%0d lat=%0d bresp=%b exp lat=2 bresp=00", to, lat, r);
      end
      do_read(32'h100, d, r, lat, to);
      checks++;
      if (to || lat !== 2 || r !== 2'b00 || d !== 32'hDEADBEEF) begin
         failures++; $display("FAIL full_read to=%0d lat=%0d rresp=%b rdata=%h exp lat=2 00 deadbeef", to, lat, r, d);
      end
   endtask

   task automatic test_strobes();
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      bit          to;
      do_write(32'h100, 32'h000000AA, 4'b0001, r, lat, to);
      do_read(32'h100, d, r, lat, to);
      checks++;
      if (to || d !== 32'hDEADBEAA) begin
         failures++; $display("FAIL strb_byte0 got=%h exp=deadbeaa", d);
      end
      do_write(32'h100, 32'h12340000, 4'b1100, r, lat, to);
      do_read(32'h100, d, r, lat, to);
      checks++;
      if (to || d !== 32'h1234BEAA) begin
         failures++; $display("FAIL strb_upper got=%h exp=1234beaa", d);
      end
      do_write(32'h100, 32'hFFFFFFFF, 4'b0000, r, lat, to);
      checks++;
      if (to || r !== 2'b00) begin
         failures++; $display("FAIL strb_zero_resp got=%b exp=00", r);
      end
      do_read(32'h103, d, r, lat, to);
      checks++;
      if (to || d !== 32'h1234BEAA) begin
         failures++; $display("FAIL strb_zero_mem got=%h exp=1234beaa", d);
      end
   endtask

   task automatic test_skew();
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      bit          to;
      bit          bad = 0;
      axi_wdata = 32'hCAFEF00D; axi_wstrb = 4'hF; axi_wvalid = 1;
      axi_awaddr = 32'h200; axi_awvalid = 0; axi_bready = 0;
      checks++;
      if (axi_wready !== 1'b1) begin
         failures++; $display("FAIL skew_wready0 got=%b exp=1", axi_wready);
      end
      step();
      axi_wvalid = 0;
      checks++;
      if ({axi_wready, axi_awready, axi_bvalid} !== 3'b010) begin
         failures++; $display("FAIL skew_after_w got=%b exp=010", {axi_wready, axi_awready, axi_bvalid});
      end
      step(); step();
      axi_awvalid = 1;
      step();
      axi_awvalid = 0;
      checks++;
      if (axi_bvalid !== 1'b0) begin
         failures++; $display("FAIL skew_early_bvalid got=%b exp=0", axi_bvalid);
      end
      step();
      for (int i = 0; i < 5; i++) begin
         if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) bad = 1;
         step();
      end
      checks++;
      if (bad) begin
         failures++; $display("FAIL skew_bvalid_hold got=%b/%b exp=1/00", axi_bvalid, axi_bresp);
      end
      axi_bready = 1;
      checks++;
      if (axi_bvalid !== 1'b1) begin
         failures++; $display("FAIL skew_bvalid_before_hs got=%b exp=1", axi_bvalid);
      end
      step();
      axi_bready = 0;
      checks++;
      if (axi_bvalid !== 1'b0) begin
         failures++; $display("FAIL skew_bvalid_after_hs got=%b exp=0", axi_bvalid);
      end
      do_read(32'h200, d, r, lat, to);
      checks++;
      if (to || d !== 32'hCAFEF00D) begin
         failures++; $display("FAIL skew_readback got=%h exp=cafef00d", d);
      end
   endtask

   task automatic test_read_backpressure();
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      bit          to;
      bit          bad = 0;
      axi_araddr = 32'h100; axi_arvalid = 1; axi_rready = 0;
      step();
      axi_arvalid = 0;
      step();
      checks++;
      if (axi_rvalid !== 1'b1) begin
         failures++; $display("FAIL bp_rvalid got=%b exp=1", axi_rvalid);
      end
      axi_awaddr = 32'h300; axi_wdata = 32'h55AA55AA; axi_wstrb = 4'hF;
      axi_awvalid = 1; axi_wvalid = 1; axi_bready = 0;
      for (int i = 0; i < 4; i++) begin
         if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h1234BEAA || axi_rresp !== 2'b00 || axi_arready !== 1'b0) bad = 1;
         if (i == 0) begin
            checks++;
            if ({axi_awready, axi_wready} !== 2'b11) begin
               failures++; $display("FAIL bp_wr_ready got=%b exp=11", {axi_awready, axi_wready});
            end
         end
         if (i == 1) begin
            axi_awvalid = 0; axi_wvalid = 0;
         end
         if (i == 2) begin
            checks++;
            if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
               failures++; $display("FAIL bp_write_b got=%b/%b exp=1/00", axi_bvalid, axi_bresp);
            end
            axi_bready = 1;
         end
         if (i == 3) axi_bready = 0;
         step();
      end
      checks++;
      if (bad) begin
         failures++; $display("FAIL bp_hold rvalid=%b rdata=%h arready=%b exp=1/1234beaa/0", axi_rvalid, axi_rdata, axi_arready);
      end
      axi_rready = 1;
      step();
      axi_rready = 0;
      checks++;
      if (axi_rvalid !== 1'b0 || axi_arready !== 1'b1) begin
         failures++; $display("FAIL bp_release rvalid=%b arready=%b exp=0/1", axi_rvalid, axi_arready);
      end
      do_read(32'h300, d, r, lat, to);
      checks++;
      if (to || d !== 32'h55AA55AA) begin
         failures++; $display("FAIL bp_overlap_write got=%h exp=55aa55aa", d);
      end
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int second = -1;
      axi_araddr = 32'h100; axi_arvalid = 1; axi_rready = 1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc == 7) axi_arvalid = 0;
         if (axi_rvalid) begin
            if (first < 0) first = cyc;
            else if (second < 0) second = cyc;
         end
         step();
      end
      step();
      axi_rready = 0;
      checks++;
      if (first !== 2 || second !== 5) begin
         failures++; $display("FAIL b2b_cycles got=%0d,%0d exp=2,5", first, second);
      end
   endtask

   task automatic test_range();
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      bit          to;
      do_write(32'h0, 32'h11223344, 4'hF, r, lat, to);
      do_write(32'h4000, 32'h0BADF00D, 4'hF, r, lat, to);
`ifdef AXI_DMEM_RANGE_CHECK_EN
      checks++;
      if (to || lat !== 2 || r !== 2'b10) begin
         failures++; $display("FAIL range_wr_resp got=%b lat=%0d exp=10 lat=2", r, lat);
      end
      do_read(32'h0, d, r, lat, to);
      checks++;
      if (to || d !== 32'h11223344) begin
         failures++; $display("FAIL range_wr_suppressed got=%h exp=11223344", d);
      end
      do_read(32'h4000, d, r, lat, to);
      checks++;
      if (to || lat !== 2 || r !== 2'b10 || d !== 32'h0) begin
         failures++; $display("FAIL range_rd got=%h/%b lat=%0d exp=0/10 lat=2", d, r, lat);
      end
`else
      checks++;
      if (to || lat !== 2 || r !== 2'b00) begin
         failures++; $display("FAIL wrap_wr_resp got=%b lat=%0d exp=00 lat=2", r, lat);
      end
      do_read(32'h0, d, r, lat, to);
      checks++;
      if (to || d !== 32'h0BADF00D) begin
         failures++; $display("FAIL wrap_wr_lands got=%h exp=0badf00d", d);
      end
      do_read(32'h4000, d, r, lat, to);
      checks++;
      if (to || r !== 2'b00 || d !== 32'h0BADF00D) begin
         failures++; $display("FAIL wrap_rd got=%h/%b exp=0badf00d/00", d, r);
      end
`endif
   endtask

   task automatic test_reset_mid_write();
      logic [1:0]  r;
      logic [31:0] d;
      int          lat;
      bit          to;
      bit          bad = 0;
      bit          seen = 0;
      do_write(32'h8, 32'h01020304, 4'hF, r, lat, to);
      axi_awaddr = 32'h8; axi_wdata = 32'hFFFFFFFF; axi_wstrb = 4'hF; axi_wvalid = 1;
      step();
      axi_wvalid = 0;
      rst = 1;
      #1;
      checks++;
      if ({axi_arready, axi_awready, axi_wready, axi_bvalid} !== 4'b0000) begin
         failures++; $display("FAIL rst_mid_outputs got=%b exp=0000", {axi_arready, axi_awready, axi_wready, axi_bvalid});
      end
      step(); step();
      rst = 0;
      step();
      checks++;
      if ({axi_awready, axi_wready} !== 2'b11) begin
         failures++; $display("FAIL rst_mid_ready_back got=%b exp=11", {axi_awready, axi_wready});
      end
      axi_awvalid = 1;
      step();
      axi_awvalid = 0;
      for (int i = 0; i < 4; i++) begin
         if (axi_bvalid !== 1'b0) bad = 1;
         step();
      end
      checks++;
      if (bad) begin
         failures++; $display("FAIL rst_mid_stale_w got=bvalid exp=no bvalid");
      end
      axi_wdata = 32'hFFFFFFFF; axi_wstrb = 4'h0; axi_wvalid = 1; axi_bready = 1;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         axi_wvalid = 0;
         if (axi_bvalid) seen = 1;
      end
      step();
      axi_bready = 0;
      checks++;
      if (!seen) begin
         failures++; $display("FAIL rst_mid_complete got=no bvalid exp=bvalid");
      end
      do_read(32'h8, d, r, lat, to);
      checks++;
      if (to || d !== 32'h01020304) begin
         failures++; $display("FAIL rst_mid_mem got=%h exp=01020304", d);
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_strobes();
      test_skew();
      test_read_backpressure();
      test_back_to_back();
      test_range();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
